// File: rtl/boot_loader_ctrl_pkg.sv
// Shared state encoding, default timing constants and a width helper for the boot loader.
// The CHECK state exists only when BOOT_LOADER_CHECKSUM_EN is defined.
package boot_loader_ctrl_pkg;

    localparam logic [7:0]  DefSyncByte    = 8'hA5;
    localparam int unsigned DefBootWindow  = 50000000;
    localparam int unsigned DefByteTimeout = 1000000;

    typedef enum logic [3:0] {
        StWaitSync = 4'd0,
        StLenHi    = 4'd1,
        StLenLo    = 4'd2,
        StDataHi   = 4'd3,
        StDataLo   = 4'd4,
        StWrite    = 4'd5,
`ifdef BOOT_LOADER_CHECKSUM_EN
        StCheck    = 4'd6,
`endif
        StRun      = 4'd7,
        StError    = 4'd8
    } state_e;

    // Bits needed to hold the value v (at least one).
    function automatic int unsigned cnt_width(input int unsigned v);
        return (v < 2) ? 1 : $clog2(v + 1);
    endfunction

endpackage

// File: rtl/boot_timeout_counter.sv
// Loadable saturating down-counter: reloads to Init on reset or clear, counts down while
// enabled, and flags expiry once it has reached zero.
module boot_timeout_counter #(
    parameter int unsigned Width = 8,
    parameter int unsigned Init  = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            cnt_q <= Width'(Init);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - Width'(1);
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/boot_loader_ctrl.sv
// Boot loader sequencer: receives a length-prefixed word stream and writes it into the program
// ROM while holding the CPU in reset. Optional trailing XOR check under BOOT_LOADER_CHECKSUM_EN.
module boot_loader_ctrl
    import boot_loader_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W       = 15,
    parameter int unsigned MAX_WORDS    = 32768,
    parameter int unsigned BOOT_WINDOW  = DefBootWindow,
    parameter int unsigned BYTE_TIMEOUT = DefByteTimeout,
    parameter logic [7:0]  SYNC_BYTE    = DefSyncByte
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              rx_ready_o,
    output logic              rom_we_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic [15:0]       rom_wdata_o,
    output logic              cpu_reset_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    localparam int unsigned CntW = ADDR_W + 1;

`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam state_e AfterLoad = StCheck;
`else
    localparam state_e AfterLoad = StRun;
`endif

    state_e            state_q, state_d;
    logic              rx_ready_q, rom_we_q, cpu_reset_q, busy_q, done_q, error_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [7:0]        len_hi_q;
    logic [15:0]       len_q;
    logic [CntW-1:0]   words_q;

    logic        rx_fire, idle_en, win_expired, idle_expired, last_word;
    logic [15:0] len_rx;

    assign rx_fire   = rx_valid_i & rx_ready_q;
    assign len_rx    = {len_hi_q, rx_data_i};
    assign last_word = (32'(words_q) + 32'd1) == 32'(len_q);

`ifdef BOOT_LOADER_CHECKSUM_EN
    assign idle_en = state_q inside {StLenHi, StLenLo, StDataHi, StDataLo, StCheck};
`else
    assign idle_en = state_q inside {StLenHi, StLenLo, StDataHi, StDataLo};
`endif

    // Boot window only runs until the first sync byte; reset reloads it.
    boot_timeout_counter #(
        .Width (cnt_width(BOOT_WINDOW)),
        .Init  (BOOT_WINDOW - 1)
    ) u_window (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (1'b0),
        .en_i      (state_q == StWaitSync),
        .expired_o (win_expired)
    );

    boot_timeout_counter #(
        .Width (cnt_width(BYTE_TIMEOUT)),
        .Init  (BYTE_TIMEOUT - 1)
    ) u_idle (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (rx_fire),
        .en_i      (idle_en),
        .expired_o (idle_expired)
    );

`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0] xor_q;
    logic       sum_ok;

    assign sum_ok = (xor_q == rx_data_i);

    always_ff @(posedge clk) begin
        if (reset) begin
            xor_q <= '0;
        end else if (rx_fire && (state_q inside {StLenHi, StLenLo, StDataHi, StDataLo})) begin
            xor_q <= xor_q ^ rx_data_i;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWaitSync: begin
                if (rx_fire && (rx_data_i == SYNC_BYTE)) state_d = StLenHi;
                else if (win_expired)                    state_d = StRun;
            end
            StLenHi: begin
                if (rx_fire)           state_d = StLenLo;
                else if (idle_expired) state_d = StError;
            end
            StLenLo: begin
                if (rx_fire) begin
                    if (len_rx == '0)                   state_d = AfterLoad;
                    else if (32'(len_rx) > MAX_WORDS)   state_d = StError;
                    else                                state_d = StDataHi;
                end else if (idle_expired) begin
                    state_d = StError;
                end
            end
            StDataHi: begin
                if (rx_fire)           state_d = StDataLo;
                else if (idle_expired) state_d = StError;
            end
            StDataLo: begin
                if (rx_fire)           state_d = StWrite;
                else if (idle_expired) state_d = StError;
            end
            StWrite: state_d = last_word ? AfterLoad : StDataHi;
`ifdef BOOT_LOADER_CHECKSUM_EN
            StCheck: begin
                if (rx_fire)           state_d = sum_ok ? StRun : StError;
                else if (idle_expired) state_d = StError;
            end
`endif
            StRun, StError: state_d = state_q;
            default:        state_d = StError;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StWaitSync;
            rx_ready_q  <= 1'b1;
            rom_we_q    <= 1'b0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            len_hi_q    <= '0;
            len_q       <= '0;
            words_q     <= '0;
        end else begin
            state_q     <= state_d;
            rom_we_q    <= (state_d == StWrite);
            cpu_reset_q <= (state_d != StRun);
            done_q      <= (state_d == StRun);
            error_q     <= (state_d == StError);
`ifdef BOOT_LOADER_CHECKSUM_EN
            rx_ready_q  <= state_d inside {StWaitSync, StLenHi, StLenLo, StDataHi, StDataLo,
                                           StCheck};
            busy_q      <= state_d inside {StLenHi, StLenLo, StDataHi, StDataLo, StWrite,
                                           StCheck};
`else
            rx_ready_q  <= state_d inside {StWaitSync, StLenHi, StLenLo, StDataHi, StDataLo};
            busy_q      <= state_d inside {StLenHi, StLenLo, StDataHi, StDataLo, StWrite};
`endif
            if (rx_fire) begin
                if (state_q == StLenHi)  len_hi_q      <= rx_data_i;
                if (state_q == StLenLo)  len_q         <= len_rx;
                if (state_q == StDataHi) wdata_q[15:8] <= rx_data_i;
                if (state_q == StDataLo) wdata_q[7:0]  <= rx_data_i;
            end
            if (state_q == StWrite) begin
                words_q <= words_q + CntW'(1);
                if (32'(addr_q) != (MAX_WORDS - 1)) addr_q <= addr_q + ADDR_W'(1);
            end
        end
    end

    assign rx_ready_o  = rx_ready_q;
    assign rom_we_o    = rom_we_q;
    assign rom_addr_o  = addr_q;
    assign rom_wdata_o = wdata_q;
    assign cpu_reset_o = cpu_reset_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = error_q;

endmodule
